// File: rtl/reg_file_sb.sv
// Register file with two async read ports, two writeback ports, optional
// same-cycle bypass, per-register busy scoreboard and a sequential clear after reset.
module reg_file_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int BYPASS        = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic [ADDRESS_WIDTH-1:0] a1,
  input  logic [ADDRESS_WIDTH-1:0] a2,
  output logic [DATA_WIDTH-1:0]    rd1,
  output logic [DATA_WIDTH-1:0]    rd2,
  output logic                     busy1,
  output logic                     busy2,
  input  logic                     we3,
  input  logic [ADDRESS_WIDTH-1:0] a3,
  input  logic [DATA_WIDTH-1:0]    wd3,
  input  logic                     we4,
  input  logic [ADDRESS_WIDTH-1:0] a4,
  input  logic [DATA_WIDTH-1:0]    wd4,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  output logic                     err_collision,
  output logic                     err_waw
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic {INIT, READY} state_t;

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]    regs [NREG];
  logic [NREG-1:0]          busy, busy_next;

  logic active, wr3, wr4, iss, hit1, hit2, hit_iss;

  // Writes to x0 are dropped here, so nothing below needs to special-case them.
  assign active  = (state == READY);
  assign wr3     = active && we3 && (a3 != '0);
  assign wr4     = active && we4 && (a4 != '0);
  assign iss     = active && iss_valid && (iss_rd != '0);
  assign hit1    = (wr3 && a3 == a1) || (wr4 && a4 == a1);
  assign hit2    = (wr3 && a3 == a2) || (wr4 && a4 == a2);
  assign hit_iss = (wr3 && a3 == iss_rd) || (wr4 && a4 == iss_rd);
  assign ready   = active;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (cnt == CNT_LAST) state_next = READY;
      READY:   state_next = READY;
      default: state_next = INIT;
    endcase
  end

  // Clear before set, so an issue and a writeback to the same register leave it busy.
  always_comb begin
    busy_next = busy;
    if (wr3) busy_next[a3] = 1'b0;
    if (wr4) busy_next[a4] = 1'b0;
    if (iss) busy_next[iss_rd] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= INIT;
      cnt           <= '0;
      busy          <= '0;
      err_collision <= 1'b0;
      err_waw       <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_next;
      if (state == INIT) cnt <= cnt + 1'b1;
      if (wr3 && wr4 && a3 == a4) err_collision <= 1'b1;
      if (iss && busy[iss_rd] && !hit_iss) err_waw <= 1'b1;
    end
  end

  // NOTE: the array has no reset term; the INIT sweep zeroes it one entry per cycle instead.
  // Port B is assigned last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        regs[cnt] <= '0;
      end else begin
        if (wr3) regs[a3] <= wd3;
        if (wr4) regs[a4] <= wd4;
      end
    end
  end

  always_comb begin
    rd1 = '0;
    if (active && a1 != '0) begin
      rd1 = regs[a1];
      if (BYPASS != 0) begin
        if (wr4 && a4 == a1)      rd1 = wd4;
        else if (wr3 && a3 == a1) rd1 = wd3;
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (active && a2 != '0) begin
      rd2 = regs[a2];
      if (BYPASS != 0) begin
        if (wr4 && a4 == a2)      rd2 = wd4;
        else if (wr3 && a3 == a2) rd2 = wd3;
      end
    end
  end

  assign busy1 = active && (a1 != '0) && busy[a1] && !hit1;
  assign busy2 = active && (a2 != '0) && busy[a2] && !hit2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: drives a BYPASS=1 and a BYPASS=0 instance with the same
// stimulus and compares both against a behavioural model every cycle.
module tb_reg_file_sb;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] a1, a2, a3, a4, iss_rd;
  logic [DW-1:0] wd3, wd4;
  logic we3, we4, iss_valid;

  logic          ready_b, busy1_b, busy2_b, err_c_b, err_w_b;
  logic [DW-1:0] rd1_b, rd2_b;
  logic          ready_n, busy1_n, busy2_n, err_c_n, err_w_n;
  logic [DW-1:0] rd1_n, rd2_n;

  reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(busy1_b), .busy2(busy2_b), .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4),
    .wd4(wd4), .iss_valid(iss_valid), .iss_rd(iss_rd), .err_collision(err_c_b), .err_waw(err_w_b));

  reg_file_sb #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .ready(ready_n), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
    .busy1(busy1_n), .busy2(busy2_n), .we3(we3), .a3(a3), .wd3(wd3), .we4(we4), .a4(a4),
    .wd4(wd4), .iss_valid(iss_valid), .iss_rd(iss_rd), .err_collision(err_c_n), .err_waw(err_w_n));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  // Reference model: register contents, busy set, init progress, sticky flags.
  logic [DW-1:0] m_regs [NREG];
  bit            m_busy [NREG];
  int            m_init_edges;
  bit            m_ready, m_ec, m_ew;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit written(input logic [AW-1:0] r);
    return m_ready && r != 0 && ((we3 && a3 == r) || (we4 && a4 == r));
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] r, input bit byp);
    if (!m_ready || r == 0) return '0;
    if (byp && we4 && a4 == r) return wd4;
    if (byp && we3 && a3 == r) return wd3;
    return m_regs[r];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] r);
    return m_ready && r != 0 && m_busy[r] && !written(r);
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_ready = 0; m_init_edges = 0; m_ec = 0; m_ew = 0;
      for (int i = 0; i < NREG; i++) m_busy[i] = 0;
    end else if (!m_ready) begin
      m_regs[m_init_edges] = '0;
      m_init_edges++;
      if (m_init_edges == NREG) m_ready = 1;
    end else begin
      if (we3 && we4 && a3 == a4 && a3 != 0) m_ec = 1;
      if (iss_valid && iss_rd != 0 && m_busy[iss_rd] && !written(iss_rd)) m_ew = 1;
      if (we3 && a3 != 0) m_regs[a3] = wd3;
      if (we4 && a4 != 0) m_regs[a4] = wd4;
      if (we3) m_busy[a3] = 0;
      if (we4) m_busy[a4] = 0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_init_edges = 0; m_ready = 0; m_ec = 0; m_ew = 0;
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_b", ready_b, m_ready);
      check("rd1_b",   rd1_b,   exp_rd(a1, 1));
      check("rd2_b",   rd2_b,   exp_rd(a2, 1));
      check("busy1_b", busy1_b, exp_busy(a1));
      check("busy2_b", busy2_b, exp_busy(a2));
      check("errc_b",  err_c_b, m_ec);
      check("errw_b",  err_w_b, m_ew);
      check("ready_n", ready_n, m_ready);
      check("rd1_n",   rd1_n,   exp_rd(a1, 0));
      check("rd2_n",   rd2_n,   exp_rd(a2, 0));
      check("busy1_n", busy1_n, exp_busy(a1));
      check("busy2_n", busy2_n, exp_busy(a2));
      check("errc_n",  err_c_n, m_ec);
      check("errw_n",  err_w_n, m_ew);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    we3 = 0; we4 = 0; iss_valid = 0;
  endtask

  // Counts cycles with ready low, starting from the current cycle; capped at 100.
  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_b === 1'b1) break;
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 0; idle();
    a1 = 0; a2 = 0; a3 = 0; a4 = 0; iss_rd = 0; wd3 = 0; wd4 = 0;
    repeat (2) @(posedge clk);
    #1; chk_en = 1; rst_n = 1;
    wait_ready(n);
    check("clear_len", n, 32);

    // Preload x5, then a one-cycle reset must re-zero it.
    step(); we3 = 1; a3 = 5; wd3 = 32'hDEADBEEF; a1 = 5;
    at_neg(); check("preload_byp", rd1_b, 32'hDEADBEEF);
    step(); idle();
    at_neg(); check("preload_nob", rd1_n, 32'hDEADBEEF);
    step(); rst_n = 0;
    step(); rst_n = 1;
    #1; check("init_rd1", rd1_b, 32'h0);
    wait_ready(n);
    check("reset_len", n, 32);
    check("x5_cleared_b", rd1_b, 32'h0);
    check("x5_cleared_n", rd1_n, 32'h0);

    // Reset at cycle 10 of INIT restarts the full sweep.
    step(); rst_n = 0;
    step(); rst_n = 1;
    repeat (10) step();
    rst_n = 0;
    step(); rst_n = 1;
    wait_ready(n);
    check("restart_len", n, 32);

    // Collision: port B wins, flag sets.
    step(); a1 = 7; we3 = 1; a3 = 7; wd3 = 32'h11; we4 = 1; a4 = 7; wd4 = 32'h22;
    at_neg(); check("coll_byp", rd1_b, 32'h22); check("coll_nob_old", rd1_n, 32'h0);
    step(); idle();
    at_neg(); check("coll_x7_b", rd1_b, 32'h22); check("coll_x7_n", rd1_n, 32'h22);
    check("coll_err", err_c_b, 1'b1);

    // Without bypass the new value appears one cycle later.
    step(); a2 = 9; we3 = 1; a3 = 9; wd3 = 32'h55;
    at_neg(); check("nob_old", rd2_n, 32'h0); check("byp_new", rd2_b, 32'h55);
    step(); idle();
    at_neg(); check("nob_new", rd2_n, 32'h55);

    // x0 never changes and never goes busy.
    step(); a1 = 0; we3 = 1; a3 = 0; wd3 = 32'hFFFFFFFF; iss_valid = 1; iss_rd = 0;
    step(); idle();
    at_neg(); check("x0_rd", rd1_b, 32'h0); check("x0_busy", busy1_b, 1'b0);
    check("x0_waw", err_w_b, 1'b0);

    // Scoreboard.
    step(); iss_valid = 1; iss_rd = 12; a1 = 12;
    at_neg(); check("sb_pre", busy1_b, 1'b0);
    step(); idle();
    at_neg(); check("sb_set", busy1_b, 1'b1);
    step(); we4 = 1; a4 = 12; wd4 = 32'h33;
    at_neg(); check("sb_wb_b", busy1_b, 1'b0); check("sb_wb_n", busy1_n, 1'b0);
    step(); idle();
    at_neg(); check("sb_cleared", busy1_b, 1'b0);
    step(); iss_valid = 1; iss_rd = 12;
    step(); iss_valid = 1; iss_rd = 12; we3 = 1; a3 = 12; wd3 = 32'h44;
    step(); idle();
    at_neg(); check("sb_set_wins", busy1_b, 1'b1); check("sb_no_waw", err_w_b, 1'b0);
    step(); iss_valid = 1; iss_rd = 12;
    step(); idle();
    at_neg(); check("sb_waw", err_w_b, 1'b1);

    // Randomised traffic with occasional resets; biased towards address overlap.
    for (int i = 0; i < 2000; i++) begin
      step();
      rst_n     = ($urandom_range(299) != 0);
      we3       = $urandom_range(1);
      we4       = $urandom_range(1);
      a3        = AW'($urandom_range(31));
      a4        = ($urandom_range(3) == 0) ? a3 : AW'($urandom_range(31));
      wd3       = $urandom;
      wd4       = $urandom;
      iss_valid = ($urandom_range(2) == 0);
      iss_rd    = ($urandom_range(3) == 0) ? a3 : AW'($urandom_range(31));
      a1        = ($urandom_range(2) == 0) ? a4 : AW'($urandom_range(31));
      a2        = ($urandom_range(2) == 0) ? a3 : AW'($urandom_range(31));
    end
    step(); idle(); rst_n = 1;
    at_neg();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
